npc_ctrl: RTL

Next-PC controller for the fetch stage. It selects the value loaded into the program-counter register each cycle and drives that register's load enable. Sources are, in priority order: exception, return-from-exception, pending or live branch redirect, and sequential PC+4. It also holds redirects that arrive during stalls and traps fetch addresses that are misaligned or outside the text segment.

---
 rtl/npc_pkg.sv | 31 +++
 rtl/npc_range_chk.sv | 19 +
 rtl/npc_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// ============================================================================
// Module      : npc_pkg
// Description : Shared types and default constants for the next-PC controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package npc_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } npc_state_e;

    // Next-PC source select
    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BR   = 3'd1,
        PEND = 3'd2,
        EXC  = 3'd3,
        ERET = 3'd4
    } npc_src_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO_DEF  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI_DEF  = 32'h0000_6FFC;

endpackage

`default_nettype wire

// File: rtl/npc_range_chk.sv
// ============================================================================
// Module      : npc_range_chk
// Description : Flags a fetch address that is misaligned or outside [lo, hi].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_range_chk (
    input  logic [31:0] addr,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic        illegal
);

    assign illegal = (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);

endmodule

`default_nettype wire

// File: rtl/npc_ctrl.sv
// ============================================================================
// Module      : npc_ctrl
// Description : Fetch-stage next-PC select with stall-held redirects and
//               illegal-fetch trapping. Define NPC_DELAY_SLOT_EN for an
//               architected branch delay slot (no F/D flush on redirect).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_ctrl
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
    parameter logic [31:0] TEXT_LO  = TEXT_LO_DEF,
    parameter logic [31:0] TEXT_HI  = TEXT_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_req_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic [31:0] next_pc_o,
    output logic        pc_en_o,
    output logic        flush_fd_o,
    output logic        flush_all_o,
    output logic        fetch_fault_o,
    output logic [31:0] bad_addr_o,
    output logic        hold_o
);

    npc_state_e  r_state;
    logic [31:0] r_pend_target;
    logic        r_fault;
    logic [31:0] r_bad_addr;

    npc_src_e    w_src;
    logic        w_en;
    logic [31:0] w_seq;
    logic [31:0] w_cand;
    logic        w_illegal;
    logic        w_trap;
    logic        w_redirect;

    assign w_seq = pc_i + 32'd4;

    always_comb begin
        w_src = SEQ;
        w_en  = !stall_i;
        if (exc_req_i) begin
            w_src = EXC;
            w_en  = 1'b1;
        end else if (eret_i) begin
            w_src = ERET;
            w_en  = 1'b1;
        end else if (r_state == HOLD) begin
            // A stalled re-presentation of the branch must not re-capture
            if (!stall_i) begin
                w_src = PEND;
                w_en  = 1'b1;
            end else begin
                w_en  = 1'b0;
            end
        end else if (br_valid_i) begin
            if (!stall_i) begin
                w_src = BR;
                w_en  = 1'b1;
            end else begin
                w_en  = 1'b0;
            end
        end
    end

    always_comb begin
        w_cand = w_seq;
        case (w_src)
            BR:      w_cand = br_target_i;
            PEND:    w_cand = r_pend_target;
            EXC:     w_cand = EXC_VEC;
            ERET:    w_cand = epc_i;
            default: w_cand = w_seq;
        endcase
    end

    npc_range_chk u_range_chk (
        .addr    (w_cand),
        .lo      (TEXT_LO),
        .hi      (TEXT_HI),
        .illegal (w_illegal)
    );

    // ERET targets are CP0's responsibility, so only fetch-side sources trap
    assign w_trap     = w_en && w_illegal && (w_src != EXC) && (w_src != ERET);
    assign w_redirect = w_en && ((w_src == BR) || (w_src == PEND));

    assign next_pc_o   = reset ? RESET_PC : (w_trap ? EXC_VEC : w_cand);
    assign pc_en_o     = reset | w_en;
    assign flush_all_o = reset | exc_req_i | eret_i | w_trap;
    assign hold_o      = (r_state == HOLD);

`ifdef NPC_DELAY_SLOT_EN
    logic w_unused_redirect;
    assign w_unused_redirect = w_redirect;
    assign flush_fd_o = 1'b0;
`else
    assign flush_fd_o = !reset && w_redirect;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_pend_target <= 32'd0;
            r_fault       <= 1'b0;
            r_bad_addr    <= 32'd0;
        end else begin
            r_fault <= w_trap;
            if (w_trap) begin
                r_bad_addr <= w_cand;
            end
            if (exc_req_i || eret_i) begin
                r_state <= RUN;
            end else if (r_state == HOLD) begin
                if (!stall_i) begin
                    r_state <= RUN;
                end
            end else if (br_valid_i && stall_i) begin
                r_state       <= HOLD;
                r_pend_target <= br_target_i;
            end
        end
    end

    assign fetch_fault_o = r_fault;
    assign bad_addr_o    = r_bad_addr;

endmodule

`default_nettype wire
